// File: rtl/instr_seq_ctrl.sv
// Instruction sequencing FSM for a multicycle RV32I-style core: fetch, decode, execute, memory, writeback.
// Latency: DECODE, EXEC and WB take one cycle each; FETCH and MEM stretch until their ready input arrives.
// Backpressure: imem_ready/dmem_ready stall in place; TIMEOUT unanswered cycles trap (sticky until rst).
module instr_seq_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        lui,
  output logic        U_type,
  output logic        jal,
  output logic        jalr,
  output logic        beq,
  output logic        bne,
  output logic        blt,
  output logic        bge,
  output logic        bltu,
  output logic        bgeu,
  output logic [3:0]  ALUctl,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_TRAP = 3'd7;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR   = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT  = 4'd8, A_SLTU = 4'd9;

  // Wide enough to hold TIMEOUT itself on the cycle the trap is taken.
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   retired_q, retired_d;
  logic          trap_q, trap_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_valid;
  logic timeout_hit;

  // Opcode class decode shared by the next-state and output logic.
  always_comb begin
    is_r     = (opcode == 7'b0110011);
    is_i     = (opcode == 7'b0010011);
    is_ld    = (opcode == 7'b0000011);
    is_st    = (opcode == 7'b0100011);
    is_br    = (opcode == 7'b1100011);
    is_jal   = (opcode == 7'b1101111);
    is_jalr  = (opcode == 7'b1100111);
    is_lui   = (opcode == 7'b0110111);
    is_auipc = (opcode == 7'b0010111);
    is_valid = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
    // Last allowed wait cycle: a ready seen now still wins over the trap.
    timeout_hit = (wait_q == CW'(TIMEOUT - 1));
  end

  // State, wait counter, retire counter and trap flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  // Next-state logic; halt_req only matters at instruction boundaries (IDLE, WB, HALT).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = halt_req ? S_HALT : S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
                else if (timeout_hit) state_d = S_TRAP;
      S_DECODE: state_d = is_valid ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (is_ld | is_st) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ready) state_d = S_WB;
                else if (timeout_hit) state_d = S_TRAP;
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!halt_req) state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end

  // Wait counter is zero outside FETCH/MEM, so it always starts from zero on entry.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
      wait_d = wait_q + 1'b1;
    retired_d = (state_q == S_WB) ? retired_q + 32'd1 : retired_q;
    trap_d    = trap_q | (state_d == S_TRAP);
  end

  // Output logic: strobes from the state, decoded controls only while an instruction is in flight.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    ir_en    = (state_q == S_FETCH) && imem_ready;
    dmem_req = (state_q == S_MEM);
    MemRead  = (state_q == S_MEM) && is_ld;
    MemWrite = (state_q == S_MEM) && is_st;
    pc_en    = (state_q == S_WB);
    RegWrite = (state_q == S_WB) &&
               (is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc);
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    lui      = 1'b0;
    U_type   = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    blt      = 1'b0;
    bge      = 1'b0;
    bltu     = 1'b0;
    bgeu     = 1'b0;
    ALUctl   = A_ADD;
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      ALUSrc   = is_i | is_ld | is_st | is_jalr;
      MemtoReg = is_ld;
      lui      = is_lui;
      U_type   = is_lui | is_auipc;
      jal      = is_jal;
      jalr     = is_jalr;
      if (is_br) begin
        case (func3)
          3'b000:  begin beq  = 1'b1; ALUctl = A_SUB;  end
          3'b001:  begin bne  = 1'b1; ALUctl = A_SUB;  end
          3'b100:  begin blt  = 1'b1; ALUctl = A_SLT;  end
          3'b101:  begin bge  = 1'b1; ALUctl = A_SLT;  end
          3'b110:  begin bltu = 1'b1; ALUctl = A_SLTU; end
          3'b111:  begin bgeu = 1'b1; ALUctl = A_SLTU; end
          default: ALUctl = A_SUB;
        endcase
      end else if (is_r | is_i) begin
        // func7 picks SUB only for register-register ops; immediate adds have no SUB form.
        case (func3)
          3'b000:  ALUctl = (is_r && func7) ? A_SUB : A_ADD;
          3'b001:  ALUctl = A_SLL;
          3'b010:  ALUctl = A_SLT;
          3'b011:  ALUctl = A_SLTU;
          3'b100:  ALUctl = A_XOR;
          3'b101:  ALUctl = func7 ? A_SRA : A_SRL;
          3'b110:  ALUctl = A_OR;
          default: ALUctl = A_AND;
        endcase
      end
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule
